// File: rtl/emu_sched_pkg.sv
// Shared types and constants for the emulator time-step scheduler.
//   sched_state_t : scheduler FSM encoding (PAUSED=0, RUN=1, HALT=2)
//   DEF_DT_W      : default width of per-source step requests
//   DEF_TIME_W    : default width of the emulated-time counter
//   dt_max()      : largest value representable in a w-bit step (2**w-1)
package emu_sched_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2
    } sched_state_t;

    localparam int DEF_DT_W   = 32;
    localparam int DEF_TIME_W = 64;

    // A shift by 64 yields 0, so the subtraction still gives all-ones for w=64.
    function automatic logic [63:0] dt_max(input int w);
        dt_max = (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/emu_min_tree.sv
// Combinational minimum over N unsigned DT_W-bit values, built as a
// balanced binary tree by recursive instantiation.
//   vals    : N packed request values
//   min_val : smallest of vals
module emu_min_tree #(
    parameter int N    = 2,
    parameter int DT_W = 32
) (
    input  logic [N-1:0][DT_W-1:0] vals,
    output logic [DT_W-1:0]        min_val
);

    generate
        if (N == 1) begin : g_leaf
            assign min_val = vals[0];
        end else begin : g_node
            localparam int NL = N / 2;
            localparam int NH = N - NL;

            logic [DT_W-1:0] min_lo;
            logic [DT_W-1:0] min_hi;

            emu_min_tree #(.N(NL), .DT_W(DT_W)) u_lo (
                .vals    (vals[NL-1:0]),
                .min_val (min_lo)
            );

            emu_min_tree #(.N(NH), .DT_W(DT_W)) u_hi (
                .vals    (vals[N-1:NL]),
                .min_val (min_hi)
            );

            assign min_val = (min_hi < min_lo) ? min_hi : min_lo;
        end
    endgenerate

endmodule

// File: rtl/emu_clk_sched.sv
// Time-step scheduler for the emulator's gated clocks. Each RUN cycle it
// advances emulated time by the smallest requested step (clamped to DT_MAX
// and to the remaining time before stop_time) and pulses clk_vals for every
// source whose request matched the step taken.
//   emu_clk   : emulator clock, all state on posedge
//   emu_rst   : synchronous active-high reset
//   run_en    : 1 = advance time, 0 = pause
//   stop_time : emulated time at which to halt
//   dt_req    : per-source time to next edge, relative to emu_time
//   dt_out    : step applied in the last cycle
//   emu_time  : current emulated time
//   clk_vals  : one-cycle pulse per source whose edge was reached
//   state_o   : FSM state (PAUSED=0, RUN=1, HALT=2)
//   step_cnt  : number of steps taken, wraps
module emu_clk_sched
    import emu_sched_pkg::*;
#(
    parameter int              N      = 2,
    parameter int              DT_W   = DEF_DT_W,
    parameter int              TIME_W = DEF_TIME_W,
    parameter logic [DT_W-1:0] DT_MAX = DT_W'(dt_max(DT_W))
) (
    input  logic                   emu_clk,
    input  logic                   emu_rst,
    input  logic                   run_en,
    input  logic [TIME_W-1:0]      stop_time,
    input  logic [N-1:0][DT_W-1:0] dt_req,
    output logic [DT_W-1:0]        dt_out,
    output logic [TIME_W-1:0]      emu_time,
    output logic [N-1:0]           clk_vals,
    output logic [1:0]             state_o,
    output logic [31:0]            step_cnt
);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [DT_W-1:0]   tree_min;
    logic [DT_W-1:0]   dt_min;
    logic [DT_W-1:0]   dt_sel;
    logic [TIME_W-1:0] rem;
    logic [TIME_W:0]   sum;
    logic [N-1:0]      fire;
    logic              take_step;

    emu_min_tree #(.N(N), .DT_W(DT_W)) u_min (
        .vals    (dt_req),
        .min_val (tree_min)
    );

    // Step selection: the extra sum bit keeps emu_time+dt_sel from wrapping
    // before it is compared against stop_time.
    always_comb begin
        dt_min = (tree_min < DT_MAX) ? tree_min : DT_MAX;
        rem    = (stop_time > emu_time) ? (stop_time - emu_time) : '0;
        dt_sel = (rem < TIME_W'(dt_min)) ? rem[DT_W-1:0] : dt_min;
        sum    = {1'b0, emu_time} + (TIME_W+1)'(dt_sel);
        fire   = '0;
        for (int k = 0; k < N; k++) begin
            fire[k] = (dt_req[k] == dt_sel);
        end
    end

    // Reaching stop_time takes priority over a pause request, so the final
    // step always lands exactly on stop_time.
    always_comb begin
        state_nxt = state;
        take_step = 1'b0;
        case (state)
            PAUSED: begin
                if (run_en) begin
                    state_nxt = (emu_time < stop_time) ? RUN : HALT;
                end
            end
            RUN: begin
                if (sum >= {1'b0, stop_time}) begin
                    take_step = 1'b1;
                    state_nxt = HALT;
                end else if (!run_en) begin
                    state_nxt = PAUSED;
                end else begin
                    take_step = 1'b1;
                end
            end
            HALT: begin
                if (!run_en) begin
                    state_nxt = PAUSED;
                end else if (stop_time > emu_time) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = PAUSED;
        endcase
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state    <= PAUSED;
            emu_time <= '0;
            dt_out   <= '0;
            clk_vals <= '0;
            step_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (take_step) begin
                emu_time <= sum[TIME_W-1:0];
                dt_out   <= dt_sel;
                clk_vals <= fire;
                step_cnt <= step_cnt + 32'd1;
            end else begin
                dt_out   <= '0;
                clk_vals <= '0;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_emu_clk_sched.sv
// Directed bench for emu_clk_sched: a behavioural model predicts every
// cycle's outputs into a scoreboard queue, plus constant checks for the
// documented scenarios (periodic requesters, ties, stop clamp, pause,
// reset mid-run, zero step, DT_MAX clamp).
module tb_emu_clk_sched;

    localparam int          N      = 2;
    localparam int          DT_W   = 32;
    localparam int          TIME_W = 64;
    localparam logic [31:0] DTMAX  = 32'd1000;

    logic                   emu_clk = 1'b0;
    logic                   emu_rst;
    logic                   run_en;
    logic [TIME_W-1:0]      stop_time;
    logic [N-1:0][DT_W-1:0] dt_req;
    logic [DT_W-1:0]        dt_out;
    logic [TIME_W-1:0]      emu_time;
    logic [N-1:0]           clk_vals;
    logic [1:0]             state_o;
    logic [31:0]            step_cnt;

    emu_clk_sched #(
        .N      (N),
        .DT_W   (DT_W),
        .TIME_W (TIME_W),
        .DT_MAX (DTMAX)
    ) dut (
        .emu_clk   (emu_clk),
        .emu_rst   (emu_rst),
        .run_en    (run_en),
        .stop_time (stop_time),
        .dt_req    (dt_req),
        .dt_out    (dt_out),
        .emu_time  (emu_time),
        .clk_vals  (clk_vals),
        .state_o   (state_o),
        .step_cnt  (step_cnt)
    );

    always #5 emu_clk = ~emu_clk;

    typedef struct {
        logic [63:0] t;
        logic [31:0] dt;
        logic [1:0]  cv;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int                m_state = 0;
    longint unsigned   m_time  = 0;
    logic [31:0]       m_dt    = '0;
    logic [1:0]        m_clk   = '0;
    logic [31:0]       m_cnt   = '0;
    longint unsigned   nxt[2];
    longint unsigned   per[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        longint unsigned dmin, rem, sel;
        logic [1:0]      f;
        bit              hit;
        if (emu_rst) begin
            m_state = 0; m_time = 0; m_dt = '0; m_clk = '0; m_cnt = '0;
            return;
        end
        dmin = longint'(DTMAX);
        for (int k = 0; k < N; k++)
            if (longint'(dt_req[k]) < dmin) dmin = longint'(dt_req[k]);
        rem = (stop_time > m_time) ? (stop_time - m_time) : 0;
        sel = (dmin < rem) ? dmin : rem;
        for (int k = 0; k < N; k++) f[k] = (longint'(dt_req[k]) == sel);
        hit = (m_time + sel >= stop_time);
        case (m_state)
            0: begin
                if (run_en) m_state = (m_time < stop_time) ? 1 : 2;
                m_dt = '0; m_clk = '0;
            end
            1: begin
                if (hit || run_en) begin
                    m_time = m_time + sel;
                    m_dt   = 32'(sel);
                    m_clk  = f;
                    m_cnt  = m_cnt + 32'd1;
                    if (hit) m_state = 2;
                end else begin
                    m_dt = '0; m_clk = '0; m_state = 0;
                end
            end
            default: begin
                m_dt = '0; m_clk = '0;
                if (!run_en) m_state = 0;
                else if (stop_time > m_time) m_state = 1;
            end
        endcase
    endtask

    task automatic step();
        exp_t e, o;
        model_edge();
        e = '{m_time, m_dt, m_clk, 2'(m_state), m_cnt};
        sb.push_back(e);
        @(posedge emu_clk);
        #1;
        o = sb.pop_front();
        chk("sb_emu_time", emu_time, o.t);
        chk("sb_dt_out", 64'(dt_out), 64'(o.dt));
        chk("sb_clk_vals", 64'(clk_vals), 64'(o.cv));
        chk("sb_state", 64'(state_o), 64'(o.st));
        chk("sb_step_cnt", 64'(step_cnt), 64'(o.cnt));
    endtask

    // Periodic requester: request is distance to next edge from model time,
    // and advances its edge whenever its expected clk_vals bit pulsed.
    task automatic step_req();
        for (int k = 0; k < N; k++) dt_req[k] = 32'(nxt[k] - m_time);
        step();
        for (int k = 0; k < N; k++) if (m_clk[k]) nxt[k] = nxt[k] + per[k];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned et[6] = '{10, 20, 25, 30, 40, 50};
        logic [1:0]      ec[6] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

        emu_rst   = 1'b1;
        run_en    = 1'b0;
        stop_time = 64'd1000;
        dt_req[0] = 32'd10;
        dt_req[1] = 32'd25;
        @(negedge emu_clk);
        step();
        step();
        chk("rst_time", emu_time, 64'd0);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_clk_vals", 64'(clk_vals), 64'd0);

        // Periodic requesters 10 and 25
        emu_rst = 1'b0;
        run_en  = 1'b1;
        per[0] = 10; per[1] = 25;
        nxt[0] = 10; nxt[1] = 25;
        step_req();
        chk("enter_run", 64'(state_o), 64'd1);
        for (int i = 0; i < 6; i++) begin
            step_req();
            chk("period_time", emu_time, et[i]);
            chk("period_clk", 64'(clk_vals), 64'(ec[i]));
            if (i == 0) chk("first_dt", 64'(dt_out), 64'd10);
        end

        // Tie
        dt_req[0] = 32'd7;
        dt_req[1] = 32'd7;
        step();
        chk("tie_dt", 64'(dt_out), 64'd7);
        chk("tie_clk", 64'(clk_vals), 64'd3);
        chk("tie_time", emu_time, 64'd57);

        // Stop-time clamp
        emu_rst = 1'b1;
        step();
        emu_rst   = 1'b0;
        stop_time = 64'd35;
        per[0] = 10; per[1] = 10;
        nxt[0] = 10; nxt[1] = 10;
        step_req();
        step_req();
        step_req();
        step_req();
        chk("pre_stop_time", emu_time, 64'd30);
        step_req();
        chk("stop_dt", 64'(dt_out), 64'd5);
        chk("stop_time", emu_time, 64'd35);
        chk("stop_clk", 64'(clk_vals), 64'd0);
        chk("stop_state", 64'(state_o), 64'd2);
        stop_time = 64'd100;
        step_req();
        chk("resume_state", 64'(state_o), 64'd1);
        step_req();
        chk("resume_dt", 64'(dt_out), 64'd5);
        chk("resume_clk", 64'(clk_vals), 64'd3);
        chk("resume_time", emu_time, 64'd40);

        // Pause for 3 cycles
        run_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_req();
            chk("pause_time", emu_time, 64'd40);
            chk("pause_dt", 64'(dt_out), 64'd0);
            chk("pause_clk", 64'(clk_vals), 64'd0);
            chk("pause_state", 64'(state_o), 64'd0);
        end
        run_en = 1'b1;
        step_req();
        chk("unpause_hold", emu_time, 64'd40);
        step_req();
        chk("unpause_time", emu_time, 64'd50);
        chk("unpause_dt", 64'(dt_out), 64'd10);

        // Reset mid-run at emu_time=500
        emu_rst = 1'b1;
        step();
        emu_rst   = 1'b0;
        stop_time = 64'd1000;
        dt_req[0] = 32'd250;
        dt_req[1] = 32'd300;
        step();
        step();
        step();
        chk("prerst_time", emu_time, 64'd500);
        chk("prerst_cnt", 64'(step_cnt), 64'd2);
        emu_rst = 1'b1;
        step();
        chk("midrst_time", emu_time, 64'd0);
        chk("midrst_cnt", 64'(step_cnt), 64'd0);
        chk("midrst_state", 64'(state_o), 64'd0);
        chk("midrst_dt", 64'(dt_out), 64'd0);

        // Zero-length step
        emu_rst   = 1'b0;
        dt_req[0] = 32'd0;
        dt_req[1] = 32'd5;
        step();
        step();
        chk("zero_dt", 64'(dt_out), 64'd0);
        chk("zero_time", emu_time, 64'd0);
        chk("zero_clk", 64'(clk_vals), 64'd1);
        step();
        chk("zero_repeat_clk", 64'(clk_vals), 64'd1);
        chk("zero_repeat_cnt", 64'(step_cnt), 64'd2);

        // All requests above DT_MAX
        dt_req[0] = 32'd2000;
        dt_req[1] = 32'd3000;
        stop_time = 64'd100000;
        step();
        chk("dtmax_dt", 64'(dt_out), 64'(DTMAX));
        chk("dtmax_clk", 64'(clk_vals), 64'd0);
        chk("dtmax_time", emu_time, 64'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
